commit_trace_checker: RTL and testbench

// - Synthesizable, parametrised successor to the printf-style pipeline bench.
// - Watches the register-file writeback port of the Pipeline core each clock.
// - Compares every committed write against an expected {addr,data} trace held in an internal FIFO.
// - Reports pass/fail, commit/mismatch/cycle counts, first-error details and a no-progress timeout.
// - Instantiated beside the Pipeline in the bench or on an FPGA debug build.

---
 rtl/commit_check_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/commit_trace_checker.sv | 125 ++++++++++++
 tb/tb_commit_trace_checker.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/commit_check_pkg.sv
// Shared encodings and types for the commit trace checker.
package commit_check_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned REG_ZERO   = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_DONE    = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_e;

  // Default-width expected entry; the checker builds a parametrised twin of this layout.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } exp_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty; push and pop may coincide.
module sync_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;

  always_comb begin
    count_d = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (PTR_W+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wptr_q] <= wdata;
  end

  assign rdata = mem[rptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/commit_trace_checker.sv
// Checks core register writebacks against a queued expected {addr,data} trace.
module commit_trace_checker
  import commit_check_pkg::*;
#(
  parameter int unsigned DATA_W           = DEF_DATA_W,
  parameter int unsigned ADDR_W           = DEF_ADDR_W,
  parameter int unsigned DEPTH            = 16,
  parameter int unsigned CNT_W            = 16,
  parameter int unsigned TIMEOUT_CYCLES   = 1000,
  parameter bit          STOP_ON_MISMATCH = 1'b0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              exp_done,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [31:0]       wb_pc,
  output logic [1:0]        state,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  commit_count,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic [31:0]       cycle_count,
  output logic [31:0]       err_pc,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_exp_data,
  output logic [DATA_W-1:0] err_act_data
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e              state_q;
  entry_t              head;
  logic [ADDR_W+DATA_W-1:0] fifo_rdata;
  logic                fifo_full, fifo_empty, push, pop;
  logic                commit, miss, finish, stop, tmo, done_seen_q;
  logic [CNT_W-1:0]    timer_q, timer_d, mismatch_d;

  assign exp_ready = !fifo_full;
  assign push      = exp_valid && !fifo_full;
  assign head      = entry_t'(fifo_rdata);

  sync_fifo #(
    .WIDTH(ADDR_W + DATA_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .push   (push),
    .wdata  ({exp_addr, exp_data}),
    .pop    (pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    commit = (state_q == ST_RUN) && wb_valid && (wb_addr != ADDR_W'(REG_ZERO));
    // Empty head means an unexpected commit; same-cycle pushes are never consulted.
    pop    = commit && !fifo_empty;
    miss   = commit && (fifo_empty || head.addr != wb_addr || head.data != wb_data);
    mismatch_d = (miss && !(&mismatch_count)) ? mismatch_count + 1'b1 : mismatch_count;
    timer_d    = wb_valid ? '0 : (&timer_q ? timer_q : timer_q + 1'b1);
    finish = (done_seen_q || exp_done) && fifo_empty && !push && !wb_valid;
    stop   = STOP_ON_MISMATCH && miss;
    tmo    = (timer_d == CNT_W'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      done_seen_q    <= 1'b0;
      timer_q        <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      commit_count   <= '0;
      mismatch_count <= '0;
      cycle_count    <= '0;
      err_pc         <= '0;
      err_addr       <= '0;
      err_exp_data   <= '0;
      err_act_data   <= '0;
    end else begin
      done_seen_q <= done_seen_q || exp_done;
      unique case (state_q)
        ST_IDLE: if (start) state_q <= ST_RUN;
        ST_RUN: begin
          timer_q        <= timer_d;
          mismatch_count <= mismatch_d;
          if (!(&cycle_count)) cycle_count <= cycle_count + 1'b1;
          if (commit && !(&commit_count)) commit_count <= commit_count + 1'b1;
          if (miss && mismatch_count == '0) begin
            err_pc       <= wb_pc;
            err_addr     <= fifo_empty ? '0 : head.addr;
            err_exp_data <= fifo_empty ? '0 : head.data;
            err_act_data <= wb_data;
          end
          // A completed trace or mismatch stop takes precedence over the idle timeout.
          if (finish || stop) begin
            state_q <= ST_DONE;
            done    <= 1'b1;
            pass    <= (mismatch_d == '0);
          end else if (tmo) begin
            state_q <= ST_TIMEOUT;
            done    <= 1'b1;
            pass    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed bench for commit_trace_checker with a 20-cycle idle timeout.
module tb_commit_trace_checker;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_ready;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic        exp_done = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [31:0] wb_pc = '0;
  logic [1:0]  state;
  logic        done, pass;
  logic [15:0] commit_count, mismatch_count;
  logic [31:0] cycle_count, err_pc, err_exp_data, err_act_data;
  logic [4:0]  err_addr;

  int n_vec = 0;
  int n_err = 0;

  commit_trace_checker #(
    .DATA_W          (32),
    .ADDR_W          (5),
    .DEPTH           (16),
    .CNT_W           (16),
    .TIMEOUT_CYCLES  (20),
    .STOP_ON_MISMATCH(1'b0)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .exp_valid     (exp_valid),
    .exp_ready     (exp_ready),
    .exp_addr      (exp_addr),
    .exp_data      (exp_data),
    .exp_done      (exp_done),
    .wb_valid      (wb_valid),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .wb_pc         (wb_pc),
    .state         (state),
    .done          (done),
    .pass          (pass),
    .commit_count  (commit_count),
    .mismatch_count(mismatch_count),
    .cycle_count   (cycle_count),
    .err_pc        (err_pc),
    .err_addr      (err_addr),
    .err_exp_data  (err_exp_data),
    .err_act_data  (err_act_data)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_valid = 1'b1; exp_addr = a; exp_data = d;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic commit(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    wb_valid = 1'b1; wb_addr = a; wb_data = d; wb_pc = pc;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_done();
    exp_done = 1'b1;
    tick();
    exp_done = 1'b0;
  endtask

  task automatic run_basic(input string tag);
    push(5'd8, 32'd5);
    push(5'd9, 32'd7);
    pulse_done();
    pulse_start();
    check({tag, "_run"}, state, 2'b01);
    commit(5'd8, 32'd5, 32'h4);
    commit(5'd9, 32'd7, 32'h8);
    tick();
    check({tag, "_state"}, state, 2'b10);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_pass"}, pass, 1'b1);
    check({tag, "_commits"}, commit_count, 16'd2);
    check({tag, "_mism"}, mismatch_count, 16'd0);
    check({tag, "_cycles"}, cycle_count, 32'd3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    // Reset state
    tick();
    do_reset();
    check("rst_state", state, 2'b00);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_ready", exp_ready, 1'b1);
    check("rst_cycles", cycle_count, 32'd0);

    // 1: clean two-entry trace
    run_basic("t1");

    // 2: data mismatch then end of trace
    do_reset();
    push(5'd8, 32'd5);
    pulse_start();
    commit(5'd8, 32'd6, 32'h10);
    check("t2_mism", mismatch_count, 16'd1);
    check("t2_err_pc", err_pc, 32'h10);
    check("t2_err_addr", err_addr, 5'd8);
    check("t2_err_exp", err_exp_data, 32'd5);
    check("t2_err_act", err_act_data, 32'd6);
    check("t2_still_run", state, 2'b01);
    pulse_done();
    check("t2_state", state, 2'b10);
    check("t2_pass", pass, 1'b0);

    // 3: FIFO full handling, dropped overflow push
    do_reset();
    for (int i = 0; i < 15; i++) push(5'(i + 1), 32'(i + 100));
    check("t3_ready15", exp_ready, 1'b1);
    push(5'd16, 32'd115);
    check("t3_full", exp_ready, 1'b0);
    push(5'd30, 32'd999);
    pulse_start();
    commit(5'd1, 32'd100, 32'h100);
    check("t3_ready_pop", exp_ready, 1'b1);
    check("t3_mism0", mismatch_count, 16'd0);
    for (int i = 1; i < 16; i++) commit(5'(i + 1), 32'(i + 100), 32'(256 + 4 * i));
    pulse_done();
    check("t3_state", state, 2'b10);
    check("t3_pass", pass, 1'b1);
    check("t3_commits", commit_count, 16'd16);

    // 4: unexpected commit with empty FIFO, then a $zero write
    do_reset();
    pulse_start();
    commit(5'd10, 32'd3, 32'h20);
    check("t4_mism", mismatch_count, 16'd1);
    check("t4_err_exp", err_exp_data, 32'd0);
    check("t4_err_addr", err_addr, 5'd0);
    check("t4_err_act", err_act_data, 32'd3);
    check("t4_commits", commit_count, 16'd1);
    commit(5'd0, 32'd77, 32'h24);
    check("t4_zero_commits", commit_count, 16'd1);
    check("t4_zero_mism", mismatch_count, 16'd1);

    // 5: idle timeout after 20 RUN cycles
    do_reset();
    push(5'd8, 32'd5);
    pulse_start();
    for (int i = 0; i < 19; i++) tick();
    check("t5_pre", state, 2'b01);
    tick();
    check("t5_state", state, 2'b11);
    check("t5_done", done, 1'b1);
    check("t5_pass", pass, 1'b0);
    check("t5_cycles", cycle_count, 32'd20);
    pulse_start();
    tick();
    check("t5_frozen", state, 2'b11);
    check("t5_frozen_cyc", cycle_count, 32'd20);

    // 6: reset mid-run discards queued entries
    do_reset();
    push(5'd8, 32'd5);
    push(5'd4, 32'd4);
    pulse_start();
    commit(5'd3, 32'd3, 32'h30);
    check("t6_pre_mism", mismatch_count, 16'd1);
    do_reset();
    check("t6_state", state, 2'b00);
    check("t6_commits", commit_count, 16'd0);
    check("t6_mism", mismatch_count, 16'd0);
    check("t6_err_pc", err_pc, 32'd0);
    check("t6_err_act", err_act_data, 32'd0);
    check("t6_cycles", cycle_count, 32'd0);
    check("t6_done", done, 1'b0);
    run_basic("t6r");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
